rr_arbiter_4: RTL and testbench
===============================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one grant may stay asserted (legal range 1..255).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] high means requester i wants the shared resource.
REQ-005 The block SHALL have port gnt, output, 4 bits, registered: one-hot grant, or all-zero when no grant is given.
REQ-006 The block SHALL have port owner, output, 2 bits, registered: index of the granted requester, valid only while busy=1.
REQ-007 The block SHALL have port busy, output, 1 bit, registered: high exactly when gnt is non-zero.
REQ-008 The block SHALL have port timeout, output, 1 bit, registered: one-cycle pulse when a grant is forcibly revoked at the MAX_HOLD limit.

Function
REQ-009 The block SHALL implement two states: IDLE (gnt=0) and GRANT (gnt one-hot).
REQ-010 The block SHALL hold internal state ptr[1:0] (round-robin start index) and hold_cnt[7:0] (grant cycles elapsed).
REQ-011 In IDLE with req=0, the block SHALL stay in IDLE, leaving gnt=0 and ptr unchanged.
REQ-012 In IDLE with req!=0 at a rising edge, the block SHALL, at that same edge, enter GRANT:
- select the first i with req[i]=1 in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4);
- set gnt to the one-hot of i, owner=i, busy=1 and hold_cnt=1.
- The request-to-grant latency is therefore 1 edge.
REQ-013 In GRANT, if req[owner]=0 at an edge, the block SHALL return to IDLE:
- gnt=0 and busy=0;
- ptr=owner+1 mod 4;
- timeout=0.
REQ-014 In GRANT, if req[owner]=1 and hold_cnt=MAX_HOLD at an edge, the block SHALL return to IDLE:
- gnt=0 and busy=0;
- ptr=owner+1 mod 4;
- timeout=1 for exactly one cycle.
REQ-015 In GRANT, if req[owner]=1 and hold_cnt<MAX_HOLD, the block SHALL keep gnt and owner unchanged and increment hold_cnt.
REQ-016 Requests on non-owner lines SHALL be ignored while in GRANT.
REQ-017 Every release SHALL be followed by at least one IDLE cycle (gnt=0) before the next grant.
REQ-018 gnt SHALL never have more than one bit set in any cycle.
REQ-019 ptr SHALL change only on a release, and SHALL wrap from 3 to 0.
REQ-020 With MAX_HOLD=1, every grant SHALL last exactly one cycle, and timeout SHALL pulse whenever req[owner] is still high at the following edge.
REQ-021 timeout SHALL be 0 in every cycle except the single cycle after a forced release.

Reset
REQ-022 When reset=1 at a rising edge, the block SHALL set state=IDLE, gnt=4'b0000, owner=0, busy=0, timeout=0, ptr=0 and hold_cnt=0, regardless of req.
REQ-023 Reset SHALL take priority over all other transitions, including reset asserted mid-grant: the grant is dropped at that edge and no timeout pulse is produced.
REQ-024 Arbitration SHALL resume at the first edge with reset=0, using ptr=0.

Verification
REQ-025 Reset grant: req=4'b1111 held while reset=1 for 2 edges -> gnt=0000 throughout; first edge after reset falls -> gnt=0001, owner=0.
REQ-026 Rotation and timeout: MAX_HOLD=4, req=1111 held continuously -> gnt sequence is 0001 x4, 0000, 0010 x4, 0000, 0100 x4, 0000, 1000 x4, 0000, then 0001 again; timeout pulses in each 0000 cycle.
REQ-027 Voluntary release: req=0100 for 3 edges then 0000 -> gnt=0100 for 3 cycles, then 0000; timeout stays 0; ptr=3.
REQ-028 Pointer priority: after requester 1 releases (ptr=2), apply req=1010 -> gnt=1000; after it releases -> gnt=0010.
REQ-029 Reset mid-grant: gnt=0010 with hold_cnt=2, assert reset for 1 edge with req=1111 -> gnt=0000 and timeout=0; next edge -> gnt=0001.
REQ-030 MAX_HOLD=1: req=0011 held -> gnt alternates 0001, 0000, 0010, 0000, ...; timeout=1 in every 0000 cycle.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter with a bounded grant hold time.
//
// A grant is issued one edge after a request is seen in IDLE. The search
// starts at the round-robin pointer. The grant lasts until the owner drops
// its request or has held the resource for MAX_HOLD cycles. A forced release
// raises a one-cycle timeout pulse. Every release is followed by at least one
// idle cycle, and the pointer then moves to the requester after the old owner.
//
// Parameters
//   MAX_HOLD : maximum consecutive grant cycles (1..255)
// Ports
//   clock   : single clock, rising-edge active
//   reset   : synchronous active-high reset
//   req     : request lines, req[i] = requester i wants the resource
//   gnt     : registered one-hot grant, all-zero when idle
//   owner   : registered index of the granted requester, valid while busy
//   busy    : registered, high exactly when gnt is non-zero
//   timeout : registered one-cycle pulse after a forced release
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned HOLD_W = 8;

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [HOLD_W-1:0]   hold_cnt;

  // Combinational winner of the rotating priority search.
  logic [IDX_W-1:0]    pick_idx_c;
  logic                pick_valid_c;

  // The owner's own request line decides whether the grant continues.
  logic                owner_req_c;

  // Find the first active request starting at ptr and wrapping modulo four.
  always_comb begin
    pick_idx_c   = '0;
    pick_valid_c = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'(ptr + IDX_W'(j));
      if (!pick_valid_c && req[cand]) begin
        pick_idx_c   = cand;
        pick_valid_c = 1'b1;
      end
    end
  end

  assign owner_req_c = req[owner];

  // State machine with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A timeout pulse from the previous release lasts one cycle.
          timeout <= 1'b0;
          if (pick_valid_c) begin
            state    <= ST_GRANT;
            gnt      <= N_REQ'(1) << pick_idx_c;
            owner    <= pick_idx_c;
            busy     <= 1'b1;
            hold_cnt <= HOLD_W'(1);
          end
        end

        ST_GRANT: begin
          if (!owner_req_c) begin
            // The owner released the resource voluntarily.
            state    <= ST_IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            ptr      <= IDX_W'(owner + IDX_W'(1));
            hold_cnt <= '0;
            timeout  <= 1'b0;
          end else if (hold_cnt >= HOLD_LIMIT) begin
            // The hold limit was reached, so the grant is revoked.
            state    <= ST_IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            ptr      <= IDX_W'(owner + IDX_W'(1));
            hold_cnt <= '0;
            timeout  <= 1'b1;
          end else begin
            hold_cnt <= HOLD_W'(hold_cnt + HOLD_W'(1));
          end
        end

        default: begin
          state    <= ST_IDLE;
          gnt      <= '0;
          busy     <= 1'b0;
          hold_cnt <= '0;
          timeout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4.
// Three instances (MAX_HOLD = 8, 4, 1) share the same stimulus. Each instance
// is checked every cycle against a behavioural model built from the arbitration
// rules. Directed sequences with constant expectations are followed by a
// randomized request/reset phase.
module tb_rr_arbiter_4;

  localparam int unsigned N_INST = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;

  logic [3:0] gnt     [N_INST];
  logic [1:0] owner   [N_INST];
  logic       busy    [N_INST];
  logic       timeout [N_INST];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state, one entry per instance.
  int m_busy  [N_INST];
  int m_owner [N_INST];
  int m_ptr   [N_INST];
  int m_held  [N_INST];
  int m_tmo   [N_INST];

  always #5 clock = ~clock;

  rr_arbiter_4 #(.MAX_HOLD(8)) u_dut8 (
    .clock(clock), .reset(reset), .req(req),
    .gnt(gnt[0]), .owner(owner[0]), .busy(busy[0]), .timeout(timeout[0])
  );
  rr_arbiter_4 #(.MAX_HOLD(4)) u_dut4 (
    .clock(clock), .reset(reset), .req(req),
    .gnt(gnt[1]), .owner(owner[1]), .busy(busy[1]), .timeout(timeout[1])
  );
  rr_arbiter_4 #(.MAX_HOLD(1)) u_dut1 (
    .clock(clock), .reset(reset), .req(req),
    .gnt(gnt[2]), .owner(owner[2]), .busy(busy[2]), .timeout(timeout[2])
  );

  function automatic int hold_lim(input int k);
    case (k)
      0:       return 8;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic model_step(input logic rst, input logic [3:0] r);
    for (int k = 0; k < N_INST; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_tmo[k] = 0;
      end else if (m_busy[k] == 0) begin
        m_tmo[k] = 0;
        for (int j = 0; j < 4; j++) begin
          int idx;
          idx = (m_ptr[k] + j) % 4;
          if (m_busy[k] == 0 && r[idx]) begin
            m_busy[k] = 1; m_owner[k] = idx; m_held[k] = 1;
          end
        end
      end else if (!r[m_owner[k]]) begin
        m_busy[k] = 0; m_ptr[k] = (m_owner[k] + 1) % 4; m_tmo[k] = 0;
      end else if (m_held[k] == hold_lim(k)) begin
        m_busy[k] = 0; m_ptr[k] = (m_owner[k] + 1) % 4; m_tmo[k] = 1;
      end else begin
        m_held[k] = m_held[k] + 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < N_INST; k++) begin
      logic [3:0] exp_gnt;
      exp_gnt = (m_busy[k] != 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
      check($sformatf("gnt[%0d]", k), 32'(gnt[k]), 32'(exp_gnt));
      check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_busy[k]));
      check($sformatf("timeout[%0d]", k), 32'(timeout[k]), 32'(m_tmo[k]));
      if (m_busy[k] != 0)
        check($sformatf("owner[%0d]", k), 32'(owner[k]), 32'(m_owner[k]));
      check($sformatf("onehot[%0d]", k), 32'($countones(gnt[k]) <= 1), 32'(1));
    end
  endtask

  // Drive inputs, take one edge, then sample 1 time unit later.
  task automatic cycle(input logic rst, input logic [3:0] r);
    reset = rst;
    req   = r;
    @(posedge clock);
    model_step(rst, r);
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] r;
    logic       rst;
    logic [3:0] exp_g;

    reset = 1'b1;
    req   = 4'b0000;
    for (int k = 0; k < N_INST; k++) begin
      m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_tmo[k] = 0;
    end

    // Reset with all requests active keeps every grant at zero.
    cycle(1'b1, 4'b1111);
    cycle(1'b1, 4'b1111);
    for (int k = 0; k < N_INST; k++) check("rst_gnt", 32'(gnt[k]), 32'h0);
    cycle(1'b0, 4'b1111);
    for (int k = 0; k < N_INST; k++) begin
      check("first_gnt", 32'(gnt[k]), 32'h1);
      check("first_owner", 32'(owner[k]), 32'h0);
    end

    // Rotation with MAX_HOLD=4: four grant cycles then one timeout idle.
    // The first grant cycle above is position 0.
    for (int p = 1; p < 21; p++) begin
      cycle(1'b0, 4'b1111);
      exp_g = (p % 5 == 4) ? 4'b0000 : (4'b0001 << ((p / 5) % 4));
      check("rot4_gnt", 32'(gnt[1]), 32'(exp_g));
      check("rot4_tmo", 32'(timeout[1]), 32'(p % 5 == 4));
    end

    // Voluntary release leaves the pointer at 3.
    cycle(1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b0100);
      check("vol_gnt", 32'(gnt[0]), 32'h4);
    end
    cycle(1'b0, 4'b0000);
    check("vol_rel", 32'(gnt[0]), 32'h0);
    check("vol_tmo", 32'(timeout[0]), 32'h0);
    cycle(1'b0, 4'b1111);
    check("vol_ptr3", 32'(gnt[0]), 32'h8);

    // Pointer priority after requester 1 releases.
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0010);
    cycle(1'b0, 4'b0000);
    cycle(1'b0, 4'b1010);
    check("prio_gnt3", 32'(gnt[0]), 32'h8);
    cycle(1'b0, 4'b0010);
    check("prio_rel", 32'(gnt[0]), 32'h0);
    cycle(1'b0, 4'b0010);
    check("prio_gnt1", 32'(gnt[0]), 32'h2);

    // Reset in the middle of a grant drops it without a timeout pulse.
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0010);
    cycle(1'b0, 4'b1111);
    check("mid_hold", 32'(gnt[0]), 32'h2);
    cycle(1'b1, 4'b1111);
    check("mid_rst_gnt", 32'(gnt[0]), 32'h0);
    check("mid_rst_tmo", 32'(timeout[0]), 32'h0);
    cycle(1'b0, 4'b1111);
    check("mid_resume", 32'(gnt[0]), 32'h1);

    // MAX_HOLD=1 alternates grant and timeout idle cycles.
    cycle(1'b1, 4'b0000);
    for (int p = 0; p < 12; p++) begin
      cycle(1'b0, 4'b0011);
      case (p % 4)
        0:       exp_g = 4'b0001;
        2:       exp_g = 4'b0010;
        default: exp_g = 4'b0000;
      endcase
      check("mh1_gnt", 32'(gnt[2]), 32'(exp_g));
      check("mh1_tmo", 32'(timeout[2]), 32'(p % 2 == 1));
    end

    // Randomized requests with occasional resets, checked by the model.
    r = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3, 0) == 0) r = 4'($urandom);
      rst = ($urandom_range(99, 0) == 0);
      cycle(rst, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
